// File: rtl/register_file_pkg.sv
// ----------------------------------------------------------------------------
// register_file_pkg
//   Shared NoC constants so the flit input queue and its storage array agree
//   on the default geometry.
//     FLIT_WIDTH       : flit payload width in bits (12)
//     QUEUE_ADDR_WIDTH : input-queue pointer width (3 -> 8 entries)
// ----------------------------------------------------------------------------
package register_file_pkg;

    localparam int FLIT_WIDTH       = 12;
    localparam int QUEUE_ADDR_WIDTH = 3;

endpackage : register_file_pkg

// File: rtl/register_file.sv
// ----------------------------------------------------------------------------
// register_file
//   Single-write-port, single-read-port register array of 2^addr_width words
//   of data_width bits. Used as the storage behind the flit input queue:
//   enqueue writes at the tail pointer, dequeue reads at the head pointer.
//
//   Writes are synchronous on CLK; reads are asynchronous (D_OUT is always
//   mem[ADDR_OUT], no read enable, no output register, no write bypass).
//   A write in a cycle with RST_N=0 is always discarded.
//
//   Configuration macro:
//     REGISTER_FILE_RESET_CLEAR_EN
//       defined   : every rising CLK edge with RST_N=0 clears all entries.
//       undefined : the array ignores reset (contents persist) and stays
//                   inferable as distributed RAM.
//
//   Ports:
//     CLK       in   1           clock, rising edge
//     RST_N     in   1           synchronous, active-low reset
//     ADDR_IN   in   addr_width  write address
//     ADDR_OUT  in   addr_width  read address
//     D_IN      in   data_width  write data
//     WE        in   1           write enable, active-high
//     D_OUT     out  data_width  read data = mem[ADDR_OUT]
// ----------------------------------------------------------------------------
module register_file
    import register_file_pkg::*;
#(
    parameter int data_width = FLIT_WIDTH,
    parameter int addr_width = QUEUE_ADDR_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [addr_width-1:0] ADDR_IN,
    input  logic [addr_width-1:0] ADDR_OUT,
    input  logic [data_width-1:0] D_IN,
    input  logic                  WE,
    output logic [data_width-1:0] D_OUT
);

    localparam int DEPTH = 1 << addr_width;

    logic [data_width-1:0] mem_q [DEPTH];

    // Reset wins over WE in both builds; only the clear-enabled build
    // actually touches the contents while in reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
`ifdef REGISTER_FILE_RESET_CLEAR_EN
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
`endif
        end else if (WE) begin
            mem_q[ADDR_IN] <= D_IN;
        end
    end

    // Full decode: every address is a real entry, so no range check.
    assign D_OUT = mem_q[ADDR_OUT];

endmodule : register_file

// File: tb/tb_register_file.sv
// ----------------------------------------------------------------------------
// tb_register_file
//   Directed bench for register_file (8 x 12). A behavioural array model is
//   updated on each rising edge and compared with D_OUT on every falling
//   edge whenever the addressed entry holds a known value; directed steps
//   also check hand-computed literals.
// ----------------------------------------------------------------------------
module tb_register_file;

    localparam int DW = 12;
    localparam int AW = 3;
    localparam int N  = 1 << AW;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] addr_in;
    logic [AW-1:0] addr_out;
    logic [DW-1:0] d_in;
    logic          we;
    logic [DW-1:0] d_out;

    int passed;
    int total;

    // Behavioural model: entry values plus a known/unknown flag per entry.
    logic [DW-1:0] mdl     [N];
    bit            mdl_vld [N];

    register_file #(
        .data_width (DW),
        .addr_width (AW)
    ) dut (
        .CLK      (clk),
        .RST_N    (rst_n),
        .ADDR_IN  (addr_in),
        .ADDR_OUT (addr_out),
        .D_IN     (d_in),
        .WE       (we),
        .D_OUT    (d_out)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got 0x%03h expected 0x%03h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    // Model update: storage semantics straight from the operation rules.
    always @(posedge clk) begin
        if (!rst_n) begin
`ifdef REGISTER_FILE_RESET_CLEAR_EN
            for (int i = 0; i < N; i++) begin
                mdl[i]     = '0;
                mdl_vld[i] = 1'b1;
            end
`endif
        end else if (we) begin
            mdl[addr_in]     = d_in;
            mdl_vld[addr_in] = 1'b1;
        end
    end

    // Per-cycle compare, away from the active edge.
    always @(negedge clk) begin
        if (mdl_vld[addr_out]) begin
            check("model", d_out, mdl[addr_out]);
        end
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] v);
        addr_in = a;
        d_in    = v;
        we      = 1'b1;
        tick();
        we      = 1'b0;
    endtask

    task automatic read_chk(input string name, input logic [AW-1:0] a,
                            input logic [DW-1:0] exp);
        addr_out = a;
        #1;
        check(name, d_out, exp);
    endtask

    initial begin
        passed   = 0;
        total    = 0;
        for (int i = 0; i < N; i++) begin
            mdl[i]     = '0;
            mdl_vld[i] = 1'b0;
        end
        rst_n    = 1'b0;
        we       = 1'b0;
        addr_in  = '0;
        addr_out = '0;
        d_in     = '0;

        // Reset phase
        tick();
        tick();
`ifdef REGISTER_FILE_RESET_CLEAR_EN
        for (int i = 0; i < N; i++) begin
            read_chk("reset_zero", AW'(i), 12'h000);
        end
`endif
        rst_n = 1'b1;
        tick();

        // Write/read sweep, reads with no clock between address changes
        for (int i = 0; i < N; i++) begin
            write(AW'(i), 12'h100 + DW'(i));
        end
        for (int i = 0; i < N; i++) begin
            read_chk("sweep", AW'(i), 12'h100 + DW'(i));
        end

        // WE=0 hold
        addr_in = 3'd3;
        d_in    = 12'hFFF;
        we      = 1'b0;
        repeat (4) tick();
        read_chk("we0_hold", 3'd3, 12'h103);

        // Same-address collision: old value before the edge, new after
        addr_out = 3'd2;
        addr_in  = 3'd2;
        d_in     = 12'h555;
        we       = 1'b1;
        #1;
        check("collide_before", d_out, 12'h102);
        tick();
        we = 1'b0;
        check("collide_after", d_out, 12'h555);

        // Reset priority over WE
        rst_n   = 1'b0;
        addr_in = 3'd6;
        d_in    = 12'h777;
        we      = 1'b1;
        tick();
        we    = 1'b0;
        rst_n = 1'b1;
`ifdef REGISTER_FILE_RESET_CLEAR_EN
        read_chk("reset_prio", 3'd6, 12'h000);
`else
        read_chk("reset_prio", 3'd6, 12'h106);
`endif
        tick();

        // FIFO-style wrap 7 -> 0
        write(3'd7, 12'h0A7);
        write(3'd0, 12'h0A0);
        read_chk("wrap_7", 3'd7, 12'h0A7);
        read_chk("wrap_0", 3'd0, 12'h0A0);
`ifdef REGISTER_FILE_RESET_CLEAR_EN
        read_chk("wrap_1", 3'd1, 12'h000);
`else
        read_chk("wrap_1", 3'd1, 12'h101);
        read_chk("persist_2", 3'd2, 12'h555);
`endif
        tick();

`ifdef REGISTER_FILE_RESET_CLEAR_EN
        // Reset clear after a fresh write
        write(3'd5, 12'hABC);
        read_chk("pre_clear", 3'd5, 12'hABC);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) begin
            read_chk("clear_all", AW'(i), 12'h000);
        end
        tick();
`endif

        tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_register_file
